// File: rtl/display_7seg_scan_pkg.sv
// rtl/display_7seg_scan_pkg.sv - shared constants and hex segment table for the 7-segment scan display
package display_7seg_scan_pkg;

    localparam int DIG_W = 4;
    localparam int IDX_W = 2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low {g,f,e,d,c,b,a}; entry n sits at HEX_SEG[n]
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/display_7seg_scan_if.sv
// rtl/display_7seg_scan_if.sv - write port and display pins of the scan display
interface display_7seg_scan_if;
    import display_7seg_scan_pkg::*;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [DIG_W-1:0] wr_dato;
    logic             blank_en;
    logic [3:0]       an;
    logic [6:0]       seg;
    logic [IDX_W-1:0] scan_idx;

    modport master (
        output wr_en, wr_idx, wr_dato, blank_en,
        input  an, seg, scan_idx
    );

    modport slave (
        input  wr_en, wr_idx, wr_dato, blank_en,
        output an, seg, scan_idx
    );

endinterface

// File: rtl/display_7seg_scan_hex_a_7seg.sv
// rtl/display_7seg_scan_hex_a_7seg.sv - combinational nibble to active-low 7-segment decoder
module hex_a_7seg
    import display_7seg_scan_pkg::*;
(
    input  logic [DIG_W-1:0] i_nib,
    output logic [6:0]       o_seg
);

    assign o_seg = HEX_SEG[i_nib];

endmodule

// File: rtl/display_7seg_scan.sv
// rtl/display_7seg_scan.sv - four-digit time-multiplexed common-anode 7-segment driver
module display_7seg_scan
    import display_7seg_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int N_DIG       = 4
)(
    input  logic                 clk,
    input  logic                 reset_n,
    display_7seg_scan_if.slave   bus
);

    localparam int             PW         = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0]                 r_presc;
    logic [IDX_W-1:0]              r_scan;
    logic [N_DIG-1:0][DIG_W-1:0]   r_dig;
    logic [N_DIG-1:0]              r_an;
    logic [6:0]                    r_seg;

    logic [DIG_W-1:0]              w_cur_dig;
    logic [6:0]                    w_seg;
    logic [N_DIG-1:0]              w_lz;
    logic                          w_blank;

    assign w_cur_dig = r_dig[r_scan];

    hex_a_7seg u_hex (
        .i_nib (w_cur_dig),
        .o_seg (w_seg)
    );

    // Prescaler counts out each digit's lit time, then steps the scan index
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_scan  <= '0;
        end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
            r_scan  <= r_scan + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Digit register file, one write per cycle, no handshake
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dig <= '0;
        end else if (bus.wr_en) begin
            r_dig[bus.wr_idx] <= bus.wr_dato;
        end
    end

    // w_lz[i] is set when digit i and every higher digit are zero
    always_comb begin
        w_lz = '0;
        w_lz[N_DIG-1] = (r_dig[N_DIG-1] == '0);
        for (int i = N_DIG - 2; i >= 0; i--) begin
            w_lz[i] = w_lz[i+1] && (r_dig[i] == '0);
        end
    end

    // Digit 0 always shows, so a lone zero still reads as "0"
    assign w_blank = bus.blank_en && (r_scan != '0) && w_lz[r_scan];

    // Output registers: one cycle behind the scan index, dark when blanked
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else if (w_blank) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= ~(N_DIG'(1) << r_scan);
            r_seg <= w_seg;
        end
    end

    assign bus.an       = r_an;
    assign bus.seg      = r_seg;
    assign bus.scan_idx = r_scan;

endmodule

// File: tb/tb_display_7seg_scan.sv
// tb/tb_display_7seg_scan.sv - directed self-checking bench for display_7seg_scan
module tb_display_7seg_scan;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   k;

    display_7seg_scan_if dif ();

    display_7seg_scan #(.REFRESH_DIV(4), .N_DIG(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, required completion before 200000");
        $fatal(1, "watchdog");
    end

    function automatic int slot_of(input int kk);
        return ((kk - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] an_of(input int s);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << s);
    endfunction

    task automatic tick;
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic write_dig(input logic [1:0] idx, input logic [3:0] val);
        dif.wr_en   = 1'b1;
        dif.wr_idx  = idx;
        dif.wr_dato = val;
        tick();
        dif.wr_en   = 1'b0;
    endtask

    task automatic goto_slot(input int s);
        int n;
        n = 0;
        tick();
        while (!(slot_of(k) == s && ((k - 1) % 4) == 0) && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n >= 40) begin
            bad++;
            $display("FAIL goto_slot: slot %0d not reached, k=%0d", s, k);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) tick();
        total++;
        if (dif.an !== 4'b1111) begin
            bad++;
            $display("FAIL reset_an: got %b want 1111", dif.an);
        end
        total++;
        if (dif.seg !== 7'b1111111) begin
            bad++;
            $display("FAIL reset_seg: got %b want 1111111", dif.seg);
        end
        reset_n = 1'b1;
        k = 0;
        tick();
        total++;
        if (dif.an !== 4'b1110) begin
            bad++;
            $display("FAIL release_an: got %b want 1110", dif.an);
        end
        total++;
        if (dif.seg !== 7'b1000000) begin
            bad++;
            $display("FAIL release_seg: got %b want 1000000", dif.seg);
        end
    endtask

    task automatic test_scan;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if (dif.an !== an_of(slot_of(k))) begin
                bad++;
                $display("FAIL scan_an k=%0d: got %b want %b", k, dif.an, an_of(slot_of(k)));
            end
        end
    endtask

    task automatic test_write;
        write_dig(2'd2, 4'h5);
        write_dig(2'd1, 4'hA);
        goto_slot(1);
        total++;
        if (dif.an !== 4'b1101 || dif.seg !== 7'b0001000) begin
            bad++;
            $display("FAIL write_slot1: got an=%b seg=%b want an=1101 seg=0001000", dif.an, dif.seg);
        end
        goto_slot(2);
        total++;
        if (dif.an !== 4'b1011 || dif.seg !== 7'b0010010) begin
            bad++;
            $display("FAIL write_slot2: got an=%b seg=%b want an=1011 seg=0010010", dif.an, dif.seg);
        end
        goto_slot(3);
        total++;
        if (dif.an !== 4'b0111 || dif.seg !== 7'b1000000) begin
            bad++;
            $display("FAIL write_slot3: got an=%b seg=%b want an=0111 seg=1000000", dif.an, dif.seg);
        end
    endtask

    task automatic test_blank;
        logic [6:0] exp_seg [4];
        write_dig(2'd0, 4'h7);
        write_dig(2'd1, 4'h0);
        write_dig(2'd2, 4'h0);
        write_dig(2'd3, 4'h0);
        dif.blank_en = 1'b1;
        goto_slot(0);
        total++;
        if (dif.an !== 4'b1110 || dif.seg !== 7'b1111000) begin
            bad++;
            $display("FAIL blank_slot0: got an=%b seg=%b want an=1110 seg=1111000", dif.an, dif.seg);
        end
        for (int s = 1; s < 4; s++) begin
            goto_slot(s);
            for (int c = 0; c < 4; c++) begin
                total++;
                if (dif.an !== 4'b1111 || dif.seg !== 7'b1111111) begin
                    bad++;
                    $display("FAIL blank_dark s=%0d c=%0d: got an=%b seg=%b want an=1111 seg=1111111", s, c, dif.an, dif.seg);
                end
                if (c < 3) tick();
            end
        end
        write_dig(2'd3, 4'h1);
        exp_seg[0] = 7'b1111000;
        exp_seg[1] = 7'b1000000;
        exp_seg[2] = 7'b1000000;
        exp_seg[3] = 7'b1111001;
        for (int s = 0; s < 4; s++) begin
            goto_slot(s);
            total++;
            if (dif.an !== an_of(s) || dif.seg !== exp_seg[s]) begin
                bad++;
                $display("FAIL unblank s=%0d: got an=%b seg=%b want an=%b seg=%b", s, dif.an, dif.seg, an_of(s), exp_seg[s]);
            end
        end
    endtask

    task automatic test_live;
        goto_slot(0);
        write_dig(2'd0, 4'h3);
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (dif.an !== 4'b1110 || dif.seg !== 7'b0110000) begin
                bad++;
                $display("FAIL live c=%0d: got an=%b seg=%b want an=1110 seg=0110000", c, dif.an, dif.seg);
            end
        end
        tick();
        total++;
        if (dif.an !== 4'b1101) begin
            bad++;
            $display("FAIL live_end: got an=%b want 1101", dif.an);
        end
    endtask

    task automatic test_reset_mid;
        goto_slot(2);
        tick();
        reset_n = 1'b0;
        tick();
        total++;
        if (dif.an !== 4'b1111 || dif.seg !== 7'b1111111) begin
            bad++;
            $display("FAIL midreset_dark: got an=%b seg=%b want an=1111 seg=1111111", dif.an, dif.seg);
        end
        reset_n = 1'b1;
        k = 0;
        tick();
        total++;
        if (dif.an !== 4'b1110 || dif.seg !== 7'b1000000 || dif.scan_idx !== 2'd0) begin
            bad++;
            $display("FAIL midreset_restart: got an=%b seg=%b idx=%0d want an=1110 seg=1000000 idx=0", dif.an, dif.seg, dif.scan_idx);
        end
        goto_slot(1);
        total++;
        if (dif.an !== 4'b1111 || dif.seg !== 7'b1111111) begin
            bad++;
            $display("FAIL midreset_cleared: got an=%b seg=%b want an=1111 seg=1111111", dif.an, dif.seg);
        end
        dif.blank_en = 1'b0;
        goto_slot(3);
        total++;
        if (dif.an !== 4'b0111 || dif.seg !== 7'b1000000) begin
            bad++;
            $display("FAIL midreset_slot3: got an=%b seg=%b want an=0111 seg=1000000", dif.an, dif.seg);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        k            = 0;
        reset_n      = 1'b0;
        dif.wr_en    = 1'b0;
        dif.wr_idx   = 2'd0;
        dif.wr_dato  = 4'h0;
        dif.blank_en = 1'b0;
        @(negedge clk);
        test_reset();
        test_scan();
        test_write();
        test_blank();
        test_live();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
